// File: rtl/bvashr_sge_witness_search_pkg.sv
// Shared definitions for the arithmetic-shift / signed-compare witness search.
//   WIDTH    : operand width of x, s and t
//   EVAL_W   : width of the predicate-evaluation counter (max 17)
//   state_t  : controller state encoding
//   SH_FULL  : shift amount at and above which the result is pure sign fill
//   CNT_LAST : last scan candidate value before giving up
package bvashr_sge_witness_search_pkg;

    localparam int WIDTH  = 4;
    localparam int EVAL_W = 5;

    localparam logic [WIDTH-1:0] SH_FULL  = WIDTH'(WIDTH);
    localparam logic [WIDTH-1:0] CNT_LAST = '1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CHECK = 2'd1,
        SCAN  = 2'd2,
        DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/bvashr_sge_witness_search_eval.sv
// Combinational predicate P(x) = (x >>a s) >=s t.
//   x   : value under test
//   s   : unsigned shift amount; s >= WIDTH gives full sign fill
//   t   : two's complement bound
//   sat : 1 when P(x) holds
module bvashr_sge_eval
    import bvashr_sge_witness_search_pkg::*;
(
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] s,
    input  logic [WIDTH-1:0] t,
    output logic             sat
);

    logic signed [WIDTH-1:0] sh;

    always_comb begin
        // Large shifts are clamped explicitly so the result never depends on
        // how a tool treats out-of-range shift amounts.
        if (s >= SH_FULL) begin
            sh = {WIDTH{x[WIDTH-1]}};
        end else begin
            sh = $signed(x) >>> s;
        end
        sat = (sh >= $signed(t));
    end

endmodule

// File: rtl/bvashr_sge_witness_search.sv
// Witness search for P(x) = (x >>a s) >=s t over x in 0..WIDTH-bit range.
// Checks a supplied candidate, then scans upward from 0 for the smallest
// witness, reporting how many predicate evaluations were needed.
//   clk, rst         : clock, asynchronous active-high reset
//   in_valid/ready   : request handshake carrying in_s, in_t, in_cand
//   out_valid/ready  : result handshake
//   out_found        : a witness exists
//   out_x            : smallest witness (0 when none)
//   out_cand_ok      : candidate satisfies P
//   out_evals        : predicate evaluations performed (2..17)
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | waiting for a request, in_ready=1
// CHECK | evaluate candidate, clear scan counter, evals=1
// SCAN  | evaluate P(counter) each cycle until hit or counter=15 misses
// DONE  | hold result with out_valid=1 until out_ready
module bvashr_sge_witness_search
    import bvashr_sge_witness_search_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WIDTH-1:0]  in_s,
    input  logic [WIDTH-1:0]  in_t,
    input  logic [WIDTH-1:0]  in_cand,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_found,
    output logic [WIDTH-1:0]  out_x,
    output logic              out_cand_ok,
    output logic [EVAL_W-1:0] out_evals
);

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   s_q, s_d;
    logic [WIDTH-1:0]   t_q, t_d;
    logic [WIDTH-1:0]   cand_q, cand_d;
    logic [WIDTH-1:0]   cnt_q, cnt_d;
    logic               found_q, found_d;
    logic [WIDTH-1:0]   x_q, x_d;
    logic               cand_ok_q, cand_ok_d;
    logic [EVAL_W-1:0]  evals_q, evals_d;

    logic               cand_sat;
    logic               scan_sat;

    bvashr_sge_eval u_eval_cand (
        .x   (cand_q),
        .s   (s_q),
        .t   (t_q),
        .sat (cand_sat)
    );

    bvashr_sge_eval u_eval_scan (
        .x   (cnt_q),
        .s   (s_q),
        .t   (t_q),
        .sat (scan_sat)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            s_q       <= '0;
            t_q       <= '0;
            cand_q    <= '0;
            cnt_q     <= '0;
            found_q   <= 1'b0;
            x_q       <= '0;
            cand_ok_q <= 1'b0;
            evals_q   <= '0;
        end else begin
            state_q   <= state_d;
            s_q       <= s_d;
            t_q       <= t_d;
            cand_q    <= cand_d;
            cnt_q     <= cnt_d;
            found_q   <= found_d;
            x_q       <= x_d;
            cand_ok_q <= cand_ok_d;
            evals_q   <= evals_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        s_d       = s_q;
        t_d       = t_q;
        cand_d    = cand_q;
        cnt_d     = cnt_q;
        found_d   = found_q;
        x_d       = x_q;
        cand_ok_d = cand_ok_q;
        evals_d   = evals_q;

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    s_d     = in_s;
                    t_d     = in_t;
                    cand_d  = in_cand;
                    state_d = CHECK;
                end
            end
            CHECK: begin
                cand_ok_d = cand_sat;
                cnt_d     = '0;
                found_d   = 1'b0;
                x_d       = '0;
                evals_d   = EVAL_W'(1);
                state_d   = SCAN;
            end
            SCAN: begin
                evals_d = evals_q + EVAL_W'(1);
                if (scan_sat) begin
                    found_d = 1'b1;
                    x_d     = cnt_q;
                    state_d = DONE;
                end else if (cnt_q == CNT_LAST) begin
                    // Exhausted without a witness; stop rather than wrap.
                    found_d = 1'b0;
                    x_d     = '0;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + WIDTH'(1);
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign in_ready    = (state_q == IDLE);
    assign out_valid   = (state_q == DONE);
    assign out_found   = found_q;
    assign out_x       = x_q;
    assign out_cand_ok = cand_ok_q;
    assign out_evals   = evals_q;

endmodule

// File: tb/tb_bvashr_sge_witness_search.sv
module tb_bvashr_sge_witness_search;

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] in_s;
    logic [3:0] in_t;
    logic [3:0] in_cand;
    logic       out_valid;
    logic       out_ready;
    logic       out_found;
    logic [3:0] out_x;
    logic       out_cand_ok;
    logic [4:0] out_evals;

    int total;
    int bad;

    bvashr_sge_witness_search dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_s        (in_s),
        .in_t        (in_t),
        .in_cand     (in_cand),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_found   (out_found),
        .out_x       (out_x),
        .out_cand_ok (out_cand_ok),
        .out_evals   (out_evals)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Reference: floor-divide the signed value of x by 2^s and compare with t.
    function automatic bit pred(int s, int t, int x);
        int v, tv, d, q;
        v  = (x >= 8) ? x - 16 : x;
        tv = (t >= 8) ? t - 16 : t;
        d  = 1 << s;
        q  = (v >= 0) ? v / d : -(((-v) + d - 1) / d);
        return q >= tv;
    endfunction

    task automatic ref_model(input int s, input int t, input int c,
                             output bit found, output int x, output bit cok, output int ev);
        found = 1'b0;
        x     = 0;
        for (int i = 0; i < 16; i++) begin
            if (!found && pred(s, t, i)) begin
                found = 1'b1;
                x     = i;
            end
        end
        cok = pred(s, t, c);
        ev  = found ? x + 2 : 17;
    endtask

    task automatic issue(input int s, input int t, input int c);
        int guard;
        guard = 0;
        while (!in_ready && guard < 40) begin
            @(posedge clk); #1;
            guard++;
        end
        chk("in_ready_before_req", {31'd0, in_ready}, 32'd1);
        in_s     = 4'(s);
        in_t     = 4'(t);
        in_cand  = 4'(c);
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    // Issue a request, measure latency, compare against the model, hold the
    // result for 'hold' cycles while poking in_valid, then release it.
    task automatic run_req(input int s, input int t, input int c, input int hold);
        bit found, cok;
        int x, ev, lat;
        ref_model(s, t, c, found, x, cok, ev);
        issue(s, t, c);
        lat = 0;
        while (!out_valid && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        chk("out_valid_seen", {31'd0, out_valid}, 32'd1);
        if (!out_valid) return;
        chk("latency", lat, ev);
        chk("found", {31'd0, out_found}, {31'd0, found});
        chk("x", {28'd0, out_x}, x);
        chk("cand_ok", {31'd0, out_cand_ok}, {31'd0, cok});
        chk("evals", {27'd0, out_evals}, ev);
        chk("in_ready_in_done", {31'd0, in_ready}, 32'd0);
        if (out_cand_ok) chk("cand_ok_implies_found", {31'd0, out_found}, 32'd1);
        for (int k = 0; k < hold; k++) begin
            in_valid = 1'b1;
            in_s     = 4'($urandom_range(15));
            in_t     = 4'($urandom_range(15));
            in_cand  = 4'($urandom_range(15));
            @(posedge clk); #1;
            chk("hold_valid", {31'd0, out_valid}, 32'd1);
            chk("hold_ready", {31'd0, in_ready}, 32'd0);
            chk("hold_x", {28'd0, out_x}, x);
            chk("hold_found", {31'd0, out_found}, {31'd0, found});
            chk("hold_cand_ok", {31'd0, out_cand_ok}, {31'd0, cok});
            chk("hold_evals", {27'd0, out_evals}, ev);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("release_valid", {31'd0, out_valid}, 32'd0);
        chk("release_ready", {31'd0, in_ready}, 32'd1);
    endtask

    initial begin
        total     = 0;
        bad       = 0;
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        in_s      = '0;
        in_t      = '0;
        in_cand   = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_evals", {27'd0, out_evals}, 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Directed cases with known answers.
        run_req(0, 7, 7, 0);
        chk("d1_x", {28'd0, out_x}, 32'd7);
        chk("d1_evals", {27'd0, out_evals}, 32'd9);
        run_req(1, 7, 15, 0);
        chk("d2_found", {31'd0, out_found}, 32'd0);
        chk("d2_evals", {27'd0, out_evals}, 32'd17);
        run_req(4, 0, 8, 0);
        chk("d3_evals", {27'd0, out_evals}, 32'd2);
        chk("d3_cand_ok", {31'd0, out_cand_ok}, 32'd0);
        run_req(2, 8, 5, 5);
        chk("d4_cand_ok", {31'd0, out_cand_ok}, 32'd1);

        // Reset in the middle of an unsatisfiable scan.
        issue(1, 7, 15);
        repeat (4) @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        chk("midrst_valid", {31'd0, out_valid}, 32'd0);
        chk("midrst_ready", {31'd0, in_ready}, 32'd1);
        chk("midrst_found", {31'd0, out_found}, 32'd0);
        chk("midrst_x", {28'd0, out_x}, 32'd0);
        chk("midrst_cand_ok", {31'd0, out_cand_ok}, 32'd0);
        chk("midrst_evals", {27'd0, out_evals}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        chk("postrst_ready", {31'd0, in_ready}, 32'd1);
        run_req(0, 7, 7, 0);
        chk("postrst_x", {28'd0, out_x}, 32'd7);
        chk("postrst_evals", {27'd0, out_evals}, 32'd9);

        // Exhaustive (s,t) sweep with random candidates and random holds.
        for (int s = 0; s < 16; s++) begin
            for (int t = 0; t < 16; t++) begin
                run_req(s, t, int'($urandom_range(15)), int'($urandom_range(2)));
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
